alu_uart_if: RTL and testbench

ALU_UART_IF -- requirements
Module: alu_uart_if

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_uart_if_if.sv | 27 ++
 rtl/alu_uart_if_core.sv | 125 ++++++++++++
 rtl/byte_timer.sv | 26 ++
 rtl/alu_uart_if.sv | 44 ++++
 tb/tb_alu_uart_if.sv | 251 +++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the UART-fed ALU front end.
// The inter-byte timeout is enabled by defining ALU_UART_IF_TIMEOUT_EN.
package alu_pkg;

  localparam int DEFAULT_BUS_WIDTH      = 16;
  localparam int DEFAULT_OP_WIDTH       = 6;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

  typedef enum logic [2:0] {
    RX_A,
    RX_B,
    RX_OP,
    LATCH,
    TX_SEND,
    TX_WAIT
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  localparam logic [5:0] OP_NOR = 6'b100111;

  // A counter over n lanes still needs one bit when n == 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_uart_if_if.sv
// Bundle of the UART-side and ALU-side signals of the ALU front end.
// master = the UART/ALU environment, slave = the frame sequencer.
interface alu_uart_bus import alu_pkg::*; #(
  parameter int BUS_WIDTH = DEFAULT_BUS_WIDTH,
  parameter int OP_WIDTH  = DEFAULT_OP_WIDTH
);
  logic [7:0]           rx_data;
  logic                 rx_done;
  logic [BUS_WIDTH-1:0] alu_result;
  logic                 tx_done;
  logic [BUS_WIDTH-1:0] data_a;
  logic [BUS_WIDTH-1:0] data_b;
  logic [OP_WIDTH-1:0]  opcode;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 busy;

  modport master (
    output rx_data, rx_done, alu_result, tx_done,
    input  data_a, data_b, opcode, tx_data, tx_start, busy
  );

  modport slave (
    input  rx_data, rx_done, alu_result, tx_done,
    output data_a, data_b, opcode, tx_data, tx_start, busy
  );
endinterface

// File: rtl/alu_uart_if_core.sv
// Frame sequencer: gathers A, B and opcode bytes, latches the ALU result and
// streams it out LSB first. Optional inter-byte timeout under ALU_UART_IF_TIMEOUT_EN.
module alu_uart_if_core import alu_pkg::*; #(
  parameter int BUS_WIDTH      = DEFAULT_BUS_WIDTH,
  parameter int OP_WIDTH       = DEFAULT_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic        clk,
  input logic        rst_n,
  alu_uart_bus.slave bus
);
  localparam int            NBYTES = BUS_WIDTH / 8;
  localparam int            CW     = cnt_width(NBYTES);
  localparam logic [CW-1:0] LAST   = CW'(NBYTES - 1);

  if ((BUS_WIDTH % 8) != 0 || OP_WIDTH > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("alu_uart_if_core: unsupported BUS_WIDTH/OP_WIDTH/TIMEOUT_CYCLES");
  end

  state_t               state, state_nxt;
  logic [CW-1:0]        byte_cnt;
  logic [CW-1:0]        cnt_inc;
  logic [BUS_WIDTH-1:0] data_a, data_b, result;
  logic [OP_WIDTH-1:0]  opcode;
  logic [7:0]           tx_data;
  logic                 rx_phase, rx_accept, last_byte, timed_out;

  assign rx_phase  = (state == RX_A) || (state == RX_B) || (state == RX_OP);
  assign rx_accept = bus.rx_done && rx_phase;
  assign last_byte = (byte_cnt == LAST);
  assign cnt_inc   = byte_cnt + 1'b1;

`ifdef ALU_UART_IF_TIMEOUT_EN
  logic timer_en;

  // Only a frame that has actually started can time out.
  assign timer_en = rx_phase && ((state != RX_A) || (byte_cnt != '0));

  byte_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_byte_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .kick    (rx_accept),
    .enable  (timer_en),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_A;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      RX_A:    if (rx_accept && last_byte) state_nxt = RX_B;
      RX_B:    if (rx_accept && last_byte) state_nxt = RX_OP;
      RX_OP:   if (rx_accept)              state_nxt = LATCH;
      LATCH:                               state_nxt = TX_SEND;
      TX_SEND:                             state_nxt = TX_WAIT;
      TX_WAIT: if (bus.tx_done)            state_nxt = last_byte ? RX_A : TX_SEND;
      default:                             state_nxt = RX_A;
    endcase
    if (timed_out) state_nxt = RX_A;
  end

  // NOTE: every data register is reset, so a frame cut by reset leaves no stale bytes behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      data_a   <= '0;
      data_b   <= '0;
      opcode   <= '0;
      result   <= '0;
      tx_data  <= '0;
    end else if (timed_out) begin
      byte_cnt <= '0;
    end else begin
      case (state)
        RX_A, RX_B: begin
          if (rx_accept) begin
            for (int i = 0; i < NBYTES; i++) begin
              if (byte_cnt == CW'(i)) begin
                if (state == RX_A) data_a[8*i +: 8] <= bus.rx_data;
                else               data_b[8*i +: 8] <= bus.rx_data;
              end
            end
            byte_cnt <= last_byte ? '0 : cnt_inc;
          end
        end
        RX_OP: if (rx_accept) opcode <= bus.rx_data[OP_WIDTH-1:0];
        LATCH: begin
          result   <= bus.alu_result;
          tx_data  <= bus.alu_result[7:0];
          byte_cnt <= '0;
        end
        TX_WAIT: begin
          if (bus.tx_done) begin
            if (last_byte) begin
              byte_cnt <= '0;
            end else begin
              // Pre-load the next lane so TX_SEND presents it immediately.
              for (int i = 0; i < NBYTES; i++) begin
                if (cnt_inc == CW'(i)) tx_data <= result[8*i +: 8];
              end
              byte_cnt <= cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data_a   = data_a;
  assign bus.data_b   = data_b;
  assign bus.opcode   = opcode;
  assign bus.tx_data  = tx_data;
  assign bus.tx_start = (state == TX_SEND);
  assign bus.busy     = (state == LATCH) || (state == TX_SEND) || (state == TX_WAIT);
endmodule

// File: rtl/byte_timer.sv
// Inter-byte watchdog: expires after TIMEOUT_CYCLES enabled cycles without a kick.
// Only built when ALU_UART_IF_TIMEOUT_EN is defined.
`ifdef ALU_UART_IF_TIMEOUT_EN
module byte_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic kick,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               count <= '0;
    else if (kick || !enable) count <= '0;
    else if (!expired)        count <= count + 1'b1;
  end

  // Fires on the TIMEOUT_CYCLES-th idle cycle since the last kick.
  assign expired = enable && !kick && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule
`endif

// File: rtl/alu_uart_if.sv
// Top level of the UART-to-ALU bridge; flat ports are bundled onto an
// alu_uart_bus for the sequencer. Optional timeout: ALU_UART_IF_TIMEOUT_EN.
module alu_uart_if import alu_pkg::*; #(
  parameter int BUS_WIDTH      = DEFAULT_BUS_WIDTH,
  parameter int OP_WIDTH       = DEFAULT_OP_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_done,
  input  logic [BUS_WIDTH-1:0] i_alu_result,
  input  logic                 i_tx_done,
  output logic [BUS_WIDTH-1:0] o_data_a,
  output logic [BUS_WIDTH-1:0] o_data_b,
  output logic [OP_WIDTH-1:0]  o_opcode,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy
);
  alu_uart_bus #(.BUS_WIDTH(BUS_WIDTH), .OP_WIDTH(OP_WIDTH)) bus ();

  assign bus.rx_data    = i_rx_data;
  assign bus.rx_done    = i_rx_done;
  assign bus.alu_result = i_alu_result;
  assign bus.tx_done    = i_tx_done;

  assign o_data_a   = bus.data_a;
  assign o_data_b   = bus.data_b;
  assign o_opcode   = bus.opcode;
  assign o_tx_data  = bus.tx_data;
  assign o_tx_start = bus.tx_start;
  assign o_busy     = bus.busy;

  alu_uart_if_core #(
    .BUS_WIDTH      (BUS_WIDTH),
    .OP_WIDTH       (OP_WIDTH),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_core (
    .clk   (clk),
    .rst_n (reset),
    .bus   (bus.slave)
  );
endmodule

// File: tb/tb_alu_uart_if.sv
// Bench for alu_uart_if: an ALU stub plus a frame-level model of operands,
// opcode and the LSB-first result byte stream; randomized frames on top of directed ones.
`timescale 1ns/1ps
module tb_alu_uart_if;
  import alu_pkg::*;

  localparam int BW = 16;
  localparam int OW = 6;
  localparam int TO = 100;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  alu_uart_bus #(.BUS_WIDTH(BW), .OP_WIDTH(OW)) bus ();

  alu_uart_if #(.BUS_WIDTH(BW), .OP_WIDTH(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_rx_data    (bus.rx_data),
    .i_rx_done    (bus.rx_done),
    .i_alu_result (bus.alu_result),
    .i_tx_done    (bus.tx_done),
    .o_data_a     (bus.data_a),
    .o_data_b     (bus.data_b),
    .o_opcode     (bus.opcode),
    .o_tx_data    (bus.tx_data),
    .o_tx_start   (bus.tx_start),
    .o_busy       (bus.busy)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Operands most recently delivered to the DUT (partial loads overwrite lanes in place).
  logic [BW-1:0] model_a = '0;
  logic [BW-1:0] model_b = '0;

  // Reference ALU: plain arithmetic on the operands; shifts use the whole of b as the amount.
  function automatic logic [BW-1:0] alu_ref(input logic [OW-1:0] op, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SRL:  return a >> b;
      OP_SRA:  return $signed(a) >>> b;
      default: return '0;
    endcase
  endfunction

  assign bus.alu_result = alu_ref(bus.opcode, bus.data_a, bus.data_b);

  task automatic pulse_rx(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one full frame and consumes the whole result stream, checking as it goes.
  task automatic run_frame(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [7:0] opb,
                           input int rx_gap, input int tx_gap, input bit poke_rx, input string tag);
    logic [7:0]    bytes [5];
    logic [BW-1:0] exp_res;
    logic [7:0]    held;
    int            w;
    bytes[0] = a[7:0];
    bytes[1] = a[15:8];
    bytes[2] = b[7:0];
    bytes[3] = b[15:8];
    bytes[4] = opb;
    for (int i = 0; i < 5; i++) begin
      pulse_rx(bytes[i]);
      if (i == 0) begin
        n_total++;
        if (bus.data_a !== {model_a[15:8], a[7:0]})
          $display("FAIL %s partial_a: got %h expected %h", tag, bus.data_a, {model_a[15:8], a[7:0]});
        else n_pass++;
      end
      if (i < 4) idle($urandom_range(0, rx_gap));
    end
    model_a = a;
    model_b = b;
    exp_res = alu_ref(opb[OW-1:0], a, b);

    n_total++;
    if (bus.opcode !== opb[OW-1:0]) $display("FAIL %s opcode: got %h expected %h", tag, bus.opcode, opb[OW-1:0]);
    else n_pass++;
    n_total++;
    if ({bus.data_a, bus.data_b} !== {a, b})
      $display("FAIL %s operands: got %h/%h expected %h/%h", tag, bus.data_a, bus.data_b, a, b);
    else n_pass++;
    n_total++;
    if ({bus.busy, bus.tx_start} !== 2'b10)
      $display("FAIL %s latch_cycle busy/start: got %b expected 10", tag, {bus.busy, bus.tx_start});
    else n_pass++;

    // Second cycle after the opcode strobe must carry the first start pulse.
    @(negedge clk);
    for (int k = 0; k < BW / 8; k++) begin
      w = 0;
      while (bus.tx_start !== 1'b1 && w < 20) begin
        @(negedge clk);
        w++;
      end
      n_total++;
      if (bus.tx_start !== 1'b1 || (k == 0 && w != 0))
        $display("FAIL %s tx_start byte%0d: got start=%b after %0d extra cycles expected 1 after 0",
                 tag, k, bus.tx_start, w);
      else n_pass++;
      n_total++;
      if (bus.tx_data !== exp_res[8*k +: 8])
        $display("FAIL %s tx_data byte%0d: got %h expected %h", tag, k, bus.tx_data, exp_res[8*k +: 8]);
      else n_pass++;
      held = exp_res[8*k +: 8];

      @(negedge clk);
      n_total++;
      if ({bus.tx_start, bus.busy, bus.tx_data} !== {2'b01, held})
        $display("FAIL %s tx_wait byte%0d start/busy/data: got %b%b/%h expected 01/%h",
                 tag, k, bus.tx_start, bus.busy, bus.tx_data, held);
      else n_pass++;

      if (poke_rx && k == 0) begin
        pulse_rx(8'($urandom));
        n_total++;
        if ({bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.busy} !== {a, b, opb[OW-1:0], held, 1'b1})
          $display("FAIL %s rx_ignored: got a=%h b=%h op=%h tx=%h busy=%b expected a=%h b=%h op=%h tx=%h busy=1",
                   tag, bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.busy, a, b, opb[OW-1:0], held);
        else n_pass++;
      end

      idle($urandom_range(0, tx_gap));
      bus.tx_done = 1'b1;
      @(negedge clk);
      bus.tx_done = 1'b0;
    end

    n_total++;
    if ({bus.busy, bus.tx_start} !== 2'b00)
      $display("FAIL %s frame_end busy/start: got %b expected 00", tag, {bus.busy, bus.tx_start});
    else n_pass++;
  endtask

  task automatic test_reset();
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    bus.tx_done = 1'b0;
    reset       = 1'b0;
    #1;
    n_total++;
    if ({bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.tx_start, bus.busy} !== '0)
      $display("FAIL reset_state: got a=%h b=%h op=%h tx=%h start=%b busy=%b expected all zero",
               bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.tx_start, bus.busy);
    else n_pass++;
    idle(3);
    reset = 1'b1;
    idle(2);
    n_total++;
    if ({bus.busy, bus.tx_start} !== 2'b00)
      $display("FAIL reset_release busy/start: got %b expected 00", {bus.busy, bus.tx_start});
    else n_pass++;
  endtask

  task automatic test_directed();
    run_frame(16'h0005, 16'h0003, 8'h20, 1, 2, 1'b0, "add_5_3");
    run_frame(16'h8000, 16'h0004, 8'h03, 1, 2, 1'b0, "sra_8000_4");
    run_frame(16'hFFFF, 16'h0001, 8'hE2, 1, 2, 1'b0, "sub_opcode_trunc");
  endtask

  task automatic test_ignore_rx();
    run_frame(16'h1234, 16'h00F0, 8'h24, 2, 3, 1'b1, "and_rx_poke");
    run_frame(16'hA5A5, 16'h0F0F, 8'h26, 1, 1, 1'b0, "xor_after_poke");
  endtask

  task automatic test_reset_mid_frame();
    pulse_rx(8'h11);
    pulse_rx(8'h22);
    pulse_rx(8'h33);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if ({bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.tx_start, bus.busy} !== '0)
      $display("FAIL mid_frame_reset: got a=%h b=%h op=%h tx=%h start=%b busy=%b expected all zero",
               bus.data_a, bus.data_b, bus.opcode, bus.tx_data, bus.tx_start, bus.busy);
    else n_pass++;
    @(negedge clk);
    reset   = 1'b1;
    model_a = '0;
    model_b = '0;
    idle(1);
    run_frame(16'h0102, 16'h0304, 8'h25, 1, 2, 1'b0, "or_after_reset");
  endtask

  task automatic test_random();
    logic [OW-1:0] ops [8];
    logic [7:0]    opb;
    ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SRA, OP_SRL, OP_NOR};
    for (int n = 0; n < 24; n++) begin
      opb = {2'($urandom), ops[$urandom_range(0, 7)]};
      run_frame(16'($urandom), (n % 3 == 0) ? 16'($urandom_range(0, 17)) : 16'($urandom), opb,
                3, 3, 1'($urandom), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++)
      run_frame(16'($urandom), 16'($urandom), {2'b10, OP_ADD ^ 6'(n & 2)}, 0, 0, 1'b0,
                $sformatf("b2b%0d", n));
  endtask

`ifdef ALU_UART_IF_TIMEOUT_EN
  task automatic test_timeout();
    pulse_rx(8'h77);
    idle(TO + 5);
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL timeout_idle busy: got %b expected 0", bus.busy);
    else n_pass++;
    model_a = {model_a[15:8], 8'h77};
    run_frame(16'h0040, 16'h0002, 8'h02, 1, 1, 1'b0, "srl_after_timeout");
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_ignore_rx();
    test_reset_mid_frame();
    test_random();
    test_back_to_back();
`ifdef ALU_UART_IF_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
